comparator_4: RTL and testbench

COMPARATOR_4 -- requirements
Module: comparator_4

---
 rtl/comparator_4_if.sv | 24 ++
 rtl/comparator_4.sv | 54 +++++
 tb/tb_comparator_4.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/comparator_4_if.sv
// Operand/result bundle for comparator_4: the master drives operands,
// the slave (the comparator) returns registered compare flags.
interface comparator_4_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             a_gt_b;
  logic             a_lt_b;
  logic             a_eq_b;
  logic             out_valid;

  modport master (
    output in_valid, signed_mode, a, b,
    input  a_gt_b, a_lt_b, a_eq_b, out_valid
  );

  modport slave (
    input  in_valid, signed_mode, a, b,
    output a_gt_b, a_lt_b, a_eq_b, out_valid
  );
endinterface

// File: rtl/comparator_4.sv
// Registered magnitude comparator, unsigned or two's-complement, one sample
// per cycle with a single cycle of latency; flags hold between samples.
module comparator_4 #(
  parameter int WIDTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  comparator_4_if.slave   bus
);

  logic signed [WIDTH:0] a_ext;
  logic signed [WIDTH:0] b_ext;
  logic gt_d, gt_q;
  logic lt_d, lt_q;
  logic eq_d, eq_q;
  logic valid_d, valid_q;

  // One extra bit, filled with the sign bit only in signed mode, lets a
  // single signed compare cover both interpretations.
  always_comb begin
    a_ext   = {bus.signed_mode & bus.a[WIDTH-1], bus.a};
    b_ext   = {bus.signed_mode & bus.b[WIDTH-1], bus.b};
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      gt_d    = (a_ext > b_ext);
      lt_d    = (a_ext < b_ext);
      eq_d    = (bus.a == bus.b);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      valid_q <= valid_d;
    end
  end

  assign bus.a_gt_b    = gt_q;
  assign bus.a_lt_b    = lt_q;
  assign bus.a_eq_b    = eq_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_comparator_4.sv
// Self-checking bench for comparator_4: directed vectors with literal
// expectations plus a per-cycle comparison against an integer-value model.
module tb_comparator_4;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;
  bit   check_en;

  logic m_gt, m_lt, m_eq, m_valid;

  comparator_4_if #(.WIDTH(4)) intf ();

  comparator_4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int toValue(input logic [3:0] v, input logic sm);
    int r;
    r = int'(v);
    if (sm && r > 7) r = r - 16;
    return r;
  endfunction

  // Reference model: results are defined from the numeric values of the
  // operands, so it updates on the same edge the DUT samples.
  always @(posedge clk) begin
    int va, vb;
    if (!rst_n) begin
      m_gt = 1'b0; m_lt = 1'b0; m_eq = 1'b0; m_valid = 1'b0;
    end else if (intf.in_valid) begin
      va = toValue(intf.a, intf.signed_mode);
      vb = toValue(intf.b, intf.signed_mode);
      m_gt = (va > vb);
      m_lt = (va < vb);
      m_eq = (va == vb);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if ({intf.a_gt_b, intf.a_lt_b, intf.a_eq_b, intf.out_valid} ==
          {m_gt, m_lt, m_eq, m_valid})
        passes++;
      else
        $display("[TB] FAIL model_cmp t=%0t got gt/lt/eq/v=%b%b%b%b want %b%b%b%b",
                 $time, intf.a_gt_b, intf.a_lt_b, intf.a_eq_b, intf.out_valid,
                 m_gt, m_lt, m_eq, m_valid);
      if (intf.out_valid) begin
        checks++;
        if ($countones({intf.a_gt_b, intf.a_lt_b, intf.a_eq_b}) == 1)
          passes++;
        else
          $display("[TB] FAIL one_hot t=%0t got flags %b want exactly one set",
                   $time, {intf.a_gt_b, intf.a_lt_b, intf.a_eq_b});
      end
    end
  end

  // Drive one cycle of inputs and return just after the edge that samples them.
  task automatic applyStimulus(input logic rst_v, input logic vld,
                               input logic sm, input logic [3:0] av,
                               input logic [3:0] bv);
    rst_n            = rst_v;
    intf.in_valid    = vld;
    intf.signed_mode = sm;
    intf.a           = av;
    intf.b           = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] exp_flags,
                             input logic exp_valid);
    logic [2:0] got;
    got = {intf.a_gt_b, intf.a_lt_b, intf.a_eq_b};
    checks++;
    if (got == exp_flags) passes++;
    else $display("[TB] FAIL %s flags got %b want %b", name, got, exp_flags);
    checks++;
    if (intf.out_valid == exp_valid) passes++;
    else $display("[TB] FAIL %s out_valid got %b want %b", name, intf.out_valid, exp_valid);
  endtask

  logic [3:0] sweep_a [8] = '{4'd0, 4'd1, 4'd0, 4'd15, 4'd14, 4'd15, 4'd5, 4'd6};
  logic [3:0] sweep_b [8] = '{4'd0, 4'd0, 4'd1, 4'd0,  4'd15, 4'd15, 4'd10, 4'd7};
  logic [2:0] sweep_e [8] = '{3'b001, 3'b100, 3'b010, 3'b100, 3'b010, 3'b001, 3'b010, 3'b010};

  initial begin
    checks   = 0;
    passes   = 0;
    check_en = 1'b0;
    m_gt = 1'b0; m_lt = 1'b0; m_eq = 1'b0; m_valid = 1'b0;

    applyStimulus(1'b0, 1'b1, 1'b0, 4'd5, 4'd3);
    check_en = 1'b1;
    checkOutput("reset_1", 3'b000, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd5, 4'd3);
    checkOutput("reset_2", 3'b000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd5, 4'd3);
      checkOutput("post_reset_idle", 3'b000, 1'b0);
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, sweep_a[i], sweep_b[i]);
      checkOutput($sformatf("unsigned_%0d", i), sweep_e[i], 1'b1);
    end

    applyStimulus(1'b1, 1'b1, 1'b1, 4'd15, 4'd0);
    checkOutput("signed_m1_vs_0", 3'b010, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd7, 4'd8);
    checkOutput("signed_7_vs_m8", 3'b100, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd8, 4'd8);
    checkOutput("signed_eq", 3'b001, 1'b1);

    applyStimulus(1'b1, 1'b1, 1'b0, 4'd9, 4'd2);
    checkOutput("hold_load", 3'b100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd15);
      checkOutput("hold_idle", 3'b100, 1'b0);
    end

    applyStimulus(1'b0, 1'b1, 1'b0, 4'd1, 4'd2);
    checkOutput("reset_discard", 3'b000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd1, 4'd2);
    checkOutput("reset_discard_next", 3'b000, 1'b0);

    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 256; i++)
        applyStimulus(1'b1, 1'b1, 1'(m), 4'(i >> 4), 4'(i & 15));
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    checkOutput("exhaustive_last", 3'b001, 1'b0);

    @(negedge clk);
    check_en = 1'b0;
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
